// File: rtl/convolution_filter.sv
// Streaming 3x3 correlation over an IM_SIZE x IM_SIZE 8-bit image with a clamped 8-bit result.
// Optional macro ABS_OUTPUT_EN: output |sum| clamped to 255 instead of clamping negatives to 0.
module convolution_filter #(
  parameter int unsigned IM_SIZE = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       data_load,
  input  logic [7:0] coeff_in,
  input  logic       coeff_load,
  output logic [7:0] data_o,
  output logic       data_write
);

  localparam int unsigned CW = (IM_SIZE > 1) ? $clog2(IM_SIZE) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(IM_SIZE - 1);
  localparam logic [CW-1:0] Two = CW'(2);

  logic        accept;
  logic [7:0]  coef_q [9];
  logic [7:0]  coef_d [9];
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [7:0]  lb1_q [IM_SIZE];
  logic [7:0]  lb2_q [IM_SIZE];
  logic [7:0]  win_q [3][3];
  logic [7:0]  win_d [3][3];
  logic        win_vld_q, win_vld_d;
  logic signed [16:0] prod_q [9];
  logic signed [16:0] prod_d [9];
  logic        prod_vld_q;
  logic signed [20:0] sum_q, sum_d;
  logic        sum_vld_q;
  logic signed [20:0] mag;
  logic [7:0]  out_q, out_d;
  logic        out_vld_q;

  // Coefficient loading has priority; pixels offered at the same time are dropped.
  assign accept = data_load & ~coeff_load;

  always_comb begin
    coef_d = coef_q;
    if (coeff_load) begin
      for (int i = 0; i < 8; i++) coef_d[i] = coef_q[i+1];
      coef_d[8] = coeff_in;
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == LastIdx) begin
        col_d = '0;
        row_d = (row_q == LastIdx) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Column 2 of the window is the newest; row 2 is the current image row.
  always_comb begin
    win_d     = win_q;
    win_vld_d = accept && (row_q >= Two) && (col_q >= Two);
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 2; j++) win_d[i][j] = win_q[i][j+1];
      end
      win_d[0][2] = lb2_q[col_q];
      win_d[1][2] = lb1_q[col_q];
      win_d[2][2] = data_i;
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      prod_d[i] = $signed({9'b0, win_q[i/3][i%3]}) * $signed({{9{coef_q[i][7]}}, coef_q[i]});
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 9; i++) sum_d = sum_d + {{4{prod_q[i][16]}}, prod_q[i]};
  end

  always_comb begin
`ifdef ABS_OUTPUT_EN
    mag = sum_q[20] ? -sum_q : sum_q;
`else
    mag = sum_q[20] ? 21'sd0 : sum_q;
`endif
    out_d = out_q;
    if (sum_vld_q) out_d = (mag > 21'sd255) ? 8'd255 : mag[7:0];
  end

  // Line buffers are gated by the row/column counters, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= data_i;
      lb2_q[col_q] <= lb1_q[col_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        coef_q[i] <= '0;
        prod_q[i] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) win_q[i][j] <= '0;
      end
      col_q      <= '0;
      row_q      <= '0;
      win_vld_q  <= 1'b0;
      prod_vld_q <= 1'b0;
      sum_q      <= '0;
      sum_vld_q  <= 1'b0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      coef_q     <= coef_d;
      col_q      <= col_d;
      row_q      <= row_d;
      win_q      <= win_d;
      win_vld_q  <= win_vld_d;
      prod_q     <= prod_d;
      prod_vld_q <= win_vld_q;
      sum_q      <= sum_d;
      sum_vld_q  <= prod_vld_q;
      out_q      <= out_d;
      out_vld_q  <= sum_vld_q;
    end
  end

  assign data_o     = out_q;
  assign data_write = out_vld_q;

endmodule

// File: tb/tb_convolution_filter.sv
// Self-checking bench for convolution_filter: directed kernels/images plus random frames,
// checked against a direct correlation model with per-output latency tracking.
module tb_convolution_filter;
  localparam int N = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_i = '0;
  logic       data_load = 1'b0;
  logic [7:0] coeff_in = '0;
  logic       coeff_load = 1'b0;
  logic [7:0] data_o;
  logic       data_write;

  convolution_filter #(.IM_SIZE(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .data_load  (data_load),
    .coeff_in   (coeff_in),
    .coeff_load (coeff_load),
    .data_o     (data_o),
    .data_write (data_write)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int out_cnt = 0;
  int img [N][N];
  int coefs[$];
  int exp_v[$];
  int exp_t[$];
  int pr = 0;
  int pc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, int obs, int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Direct correlation over the stored frame using the last nine coefficients loaded.
  function automatic int ref_out(int r, int c);
    int s = 0;
    int base = coefs.size() - 9;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += coefs[base + i*3 + j] * img[r-2+i][c-2+j];
`ifdef ABS_OUTPUT_EN
    if (s < 0) s = -s;
`endif
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst && data_write === 1'b1) begin
      if (exp_v.size() == 0) begin
        check("spurious_write", int'(data_write), 0);
      end else begin
        check("data_o", int'(data_o), exp_v.pop_front());
        check("latency", cyc, exp_t.pop_front());
        out_cnt++;
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    data_load  = 1'b0;
    coeff_load = 1'b0;
  endtask

  // Pixels offered alongside coeff_load must be ignored by the DUT.
  task automatic load_coef(int v);
    @(negedge clk);
    coeff_load = 1'b1;
    coeff_in   = v[7:0];
    data_load  = 1'($urandom_range(0, 1));
    data_i     = 8'($urandom);
    coefs.push_back(v);
  endtask

  task automatic push_pix(int v);
    @(negedge clk);
    coeff_load = 1'b0;
    data_load  = 1'b1;
    data_i     = v[7:0];
    img[pr][pc] = v;
    if (pr >= 2 && pc >= 2) begin
      exp_v.push_back(ref_out(pr, pc));
      exp_t.push_back(cyc + 4);
    end
    if (pc == N - 1) begin
      pc = 0;
      pr = (pr == N - 1) ? 0 : pr + 1;
    end else begin
      pc++;
    end
  endtask

  task automatic run_frame(int kind, bit gaps, int stop_row);
    int v;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (r == stop_row) return;
        if (gaps && $urandom_range(0, 3) == 0) idle();
        case (kind)
          0:       v = 10;
          1:       v = 4 * c;
          2:       v = 255 - 4 * c;
          3:       v = 255;
          default: v = int'($urandom_range(0, 255));
        endcase
        push_pix(v);
      end
    end
  endtask

  task automatic drain(string tag, int want);
    repeat (8) idle();
    check({tag, "_count"}, out_cnt, want);
    check({tag, "_pending"}, exp_v.size(), 0);
    out_cnt = 0;
  endtask

  initial begin
    int sobel[9];
    sobel = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    repeat (9) coefs.push_back(0);
    repeat (2) @(negedge clk);
    check("reset_write", int'(data_write), 0);
    check("reset_data", int'(data_o), 0);
    rst = 1'b0;

    // Constant image with unit kernel; latency checked per output.
    repeat (9) load_coef(1);
    run_frame(0, 1'b0, N);
    drain("const", 900);

    for (int i = 0; i < 9; i++) load_coef(sobel[i]);
    run_frame(1, 1'b0, N);
    drain("sobel_ramp", 900);

    run_frame(2, 1'b0, N);
    drain("sobel_neg", 900);

    repeat (9) load_coef(127);
    run_frame(3, 1'b0, N);
    drain("saturate", 900);

    // Eleven loads: only the last nine are retained.
    repeat (11) load_coef(int'($urandom_range(0, 255)) - 128);
    run_frame(4, 1'b1, N);
    drain("random_gaps", 900);

    // Reset in the middle of a frame.
    repeat (9) load_coef(1);
    run_frame(0, 1'b0, 10);
    check("pre_reset_data", int'(data_o), 90);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_write", int'(data_write), 0);
    check("midrst_data", int'(data_o), 0);
    data_load  = 1'b0;
    coeff_load = 1'b0;
    exp_v.delete();
    exp_t.delete();
    out_cnt = 0;
    pr = 0;
    pc = 0;
    coefs.delete();
    repeat (9) coefs.push_back(0);
    @(negedge clk);
    rst = 1'b0;

    // Coefficients are cleared by reset, so every output is zero.
    run_frame(4, 1'b0, N);
    drain("zero_coef", 900);

    repeat (9) load_coef(int'($urandom_range(0, 255)) - 128);
    run_frame(4, 1'b1, N);
    run_frame(4, 1'b0, N);
    drain("two_frames", 1800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
